// File: rtl/fifo_credit_pkg.sv
// Shared types, defaults and the round-robin grant helper used by the credit-FIFO write arbiter.
package fifo_credit_pkg;

  localparam int unsigned DEFAULT_DEPTH      = 8;
  localparam int unsigned DEFAULT_DATA_WIDTH = 32;

  // Largest requester count the helper supports; wider source IDs are truncated by the caller.
  localparam int unsigned MAX_SRC  = 32;
  localparam int unsigned SRC_ID_W = $clog2(MAX_SRC);

  typedef logic [SRC_ID_W-1:0] src_id_t;

  // Scan from last+1 modulo n and return the first requester found. This is the
  // rotate / priority-encode / unrotate chain folded into one loop. Returns last
  // when nothing is requesting; the caller gates on any-request separately.
  function automatic src_id_t rr_next_grant(input logic [MAX_SRC-1:0] req,
                                            input src_id_t            last,
                                            input int unsigned        n);
    logic [SRC_ID_W:0] idx;
    src_id_t           pick;
    logic              found;
    pick  = last;
    found = 1'b0;
    for (int unsigned off = 1; off <= MAX_SRC; off++) begin
      idx = {1'b0, last} + (SRC_ID_W+1)'(off);
      if (idx >= (SRC_ID_W+1)'(n)) begin
        idx = idx - (SRC_ID_W+1)'(n);
      end
      if (!found && (off <= n) && req[idx[SRC_ID_W-1:0]]) begin
        pick  = idx[SRC_ID_W-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/fifo_credit_tagq.sv
// Circular queue of source IDs mirroring the shared FIFO contents, one tag per stored entry.
module fifo_credit_tagq
  import fifo_credit_pkg::*;
#(
  parameter int unsigned DEPTH  = DEFAULT_DEPTH,
  parameter int unsigned ID_W   = 2,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [ID_W-1:0]   push_id,
  input  logic              pop,
  output logic [ID_W-1:0]   head_id,
  output logic              empty,
  output logic [ADDR_W:0]   count
);

  logic [ID_W-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   cnt_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (ADDR_W+1)'(1);
        2'b01:   cnt_q <= cnt_q - (ADDR_W+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= push_id;
    end
  end

  assign empty   = (cnt_q == '0);
  assign head_id = empty ? '0 : mem[rd_ptr_q];
  assign count   = cnt_q;

endmodule

// File: rtl/fifo_credit_arb.sv
// Round-robin write arbiter in front of a shared credit FIFO, with per-source outstanding quotas
// returned as the consumer pops entries.
module fifo_credit_arb
  import fifo_credit_pkg::*;
#(
  parameter int unsigned NUM_SRC    = 4,
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEFAULT_DEPTH,
  parameter int unsigned QUOTA      = 4,
  localparam int unsigned ID_W      = $clog2(NUM_SRC),
  localparam int unsigned CNT_W     = $clog2(QUOTA + 1)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_SRC-1:0]                  src_valid,
  output logic [NUM_SRC-1:0]                  src_ready,
  input  logic [NUM_SRC-1:0][DATA_WIDTH-1:0]  src_data,
  output logic                                fifo_wr_valid,
  input  logic                                fifo_wr_ready,
  output logic [DATA_WIDTH-1:0]               fifo_wr_data,
  input  logic                                fifo_rd_fire,
  output logic [ID_W-1:0]                     head_src_id,
  output logic                                head_src_valid,
  output logic [NUM_SRC-1:0][CNT_W-1:0]       src_outstanding,
  output logic                                err_underflow
);

  localparam int unsigned     ADDR_W   = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] QUOTA_C  = CNT_W'(QUOTA);
  localparam logic [ID_W-1:0]  LAST_RST = ID_W'(NUM_SRC - 1);

  logic [ID_W-1:0]               last_grant_q, lock_id_q, grant;
  logic                          lock_vld_q, err_q;
  logic [NUM_SRC-1:0]            elig, inc, dec;
  logic [MAX_SRC-1:0]            elig_ext;
  src_id_t                       last_ext;
  logic                          wr_fire, pop_ok;
  logic                          tq_empty;
  logic [ID_W-1:0]               tq_head;
  logic [ADDR_W:0]               tq_count;
  logic [NUM_SRC-1:0][CNT_W-1:0] outstanding_q, outstanding_d;

  always_comb begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      elig[i] = src_valid[i] && (outstanding_q[i] < QUOTA_C);
    end
  end

  // A lock pins the grant while the FIFO stalls so payload and target stay stable.
  always_comb begin
    elig_ext                 = '0;
    elig_ext[NUM_SRC-1:0]    = elig;
    last_ext                 = '0;
    last_ext[ID_W-1:0]       = last_grant_q;
    grant         = lock_vld_q ? lock_id_q : ID_W'(rr_next_grant(elig_ext, last_ext, NUM_SRC));
    fifo_wr_valid = lock_vld_q || (|elig);
    fifo_wr_data  = fifo_wr_valid ? src_data[grant] : '0;
    src_ready     = '0;
    if (fifo_wr_valid && fifo_wr_ready) begin
      src_ready[grant] = 1'b1;
    end
  end

  assign wr_fire = fifo_wr_valid && fifo_wr_ready;
  assign pop_ok  = fifo_rd_fire && (tq_count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= LAST_RST;
      lock_vld_q   <= 1'b0;
      lock_id_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      if (wr_fire) begin
        last_grant_q <= grant;
        lock_vld_q   <= 1'b0;
      end else if (fifo_wr_valid) begin
        lock_vld_q   <= 1'b1;
        lock_id_q    <= grant;
      end
      if (fifo_rd_fire && (tq_count == '0)) begin
        err_q <= 1'b1;
      end
    end
  end

  // Push and pop of the same source cancel; quota gating keeps counts within 0..QUOTA.
  always_comb begin
    outstanding_d = outstanding_q;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      inc[i] = wr_fire && (grant == ID_W'(i));
      dec[i] = pop_ok && (tq_head == ID_W'(i));
      if (inc[i] && !dec[i]) begin
        outstanding_d[i] = outstanding_q[i] + CNT_W'(1);
      end else if (dec[i] && !inc[i]) begin
        outstanding_d[i] = outstanding_q[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding_q <= '0;
    end else begin
      outstanding_q <= outstanding_d;
    end
  end

  fifo_credit_tagq #(
    .DEPTH (DEPTH),
    .ID_W  (ID_W)
  ) u_tagq (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (wr_fire),
    .push_id (grant),
    .pop     (pop_ok),
    .head_id (tq_head),
    .empty   (tq_empty),
    .count   (tq_count)
  );

  assign head_src_id     = tq_head;
  assign head_src_valid  = !tq_empty;
  assign src_outstanding = outstanding_q;
  assign err_underflow   = err_q;

endmodule

// File: tb/tb_fifo_credit_arb.sv
// Scoreboard bench for fifo_credit_arb: directed stimulus queues expected grants, a negedge
// monitor checks every write fire and every pop against them.
module tb_fifo_credit_arb;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [3:0]         src_valid, src_ready;
  logic [3:0][31:0]   src_data;
  logic               fifo_wr_valid, fifo_wr_ready, fifo_rd_fire;
  logic [31:0]        fifo_wr_data;
  logic [1:0]         head_src_id;
  logic               head_src_valid;
  logic [3:0][2:0]    src_outstanding;
  logic               err_underflow;

  int                 n_tests = 0;
  int                 n_fail  = 0;
  int unsigned        exp_grant[$];
  int unsigned        tag_model[$];

  always #5 clk = ~clk;

  fifo_credit_arb #(
    .NUM_SRC    (4),
    .DATA_WIDTH (32),
    .DEPTH      (8),
    .QUOTA      (4)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .src_valid       (src_valid),
    .src_ready       (src_ready),
    .src_data        (src_data),
    .fifo_wr_valid   (fifo_wr_valid),
    .fifo_wr_ready   (fifo_wr_ready),
    .fifo_wr_data    (fifo_wr_data),
    .fifo_rd_fire    (fifo_rd_fire),
    .head_src_id     (head_src_id),
    .head_src_valid  (head_src_valid),
    .src_outstanding (src_outstanding),
    .err_underflow   (err_underflow)
  );

  function automatic logic [31:0] data_of(input int unsigned id);
    return 32'hC0DE_0000 + id;
  endfunction

  function automatic logic [31:0] pk(input int unsigned a3, input int unsigned a2,
                                     input int unsigned a1, input int unsigned a0);
    return {20'd0, 3'(a3), 3'(a2), 3'(a1), 3'(a0)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic wr, input logic rd);
    src_valid     = v;
    fifo_wr_ready = wr;
    fifo_rd_fire  = rd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops are checked before the same-cycle push so simultaneous traffic orders correctly.
  always @(negedge clk) begin
    int unsigned id;
    if (rst_n === 1'b1) begin
      if (fifo_rd_fire === 1'b1) begin
        if (tag_model.size() != 0) begin
          id = tag_model.pop_front();
          chk("pop_head_id", 32'(head_src_id), id);
          chk("pop_head_valid", 32'(head_src_valid), 32'd1);
        end else begin
          chk("underflow_head_valid", 32'(head_src_valid), 32'd0);
        end
      end
      if (fifo_wr_valid === 1'b1 && fifo_wr_ready === 1'b1) begin
        if (exp_grant.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_fire: got src_ready 0x%0h, expected no write", src_ready);
        end else begin
          id = exp_grant.pop_front();
          chk("grant_ready", 32'(src_ready), 32'd1 << id);
          chk("grant_data", fifo_wr_data, data_of(id));
          tag_model.push_back(id);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100000");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4; i++) src_data[i] = data_of(i);
    rst_n = 1'b0;
    drive(4'b0000, 1'b0, 1'b0);
    #12;
    chk("rst_head_valid", 32'(head_src_valid), 32'd0);
    chk("rst_err", 32'(err_underflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Idle after reset
    drive(4'b0000, 1'b1, 1'b0);
    chk("idle_wr_valid", 32'(fifo_wr_valid), 32'd0);
    chk("idle_src_ready", 32'(src_ready), 32'd0);
    chk("idle_wr_data", fifo_wr_data, 32'd0);
    chk("idle_head_id", 32'(head_src_id), 32'd0);
    chk("idle_outstanding", 32'(src_outstanding), pk(0, 0, 0, 0));

    // First grants: 0,1,2,3,0
    exp_grant.push_back(0); exp_grant.push_back(1); exp_grant.push_back(2);
    exp_grant.push_back(3); exp_grant.push_back(0);
    for (int i = 0; i < 4; i++) begin
      drive(4'b1111, 1'b1, 1'b0);
      tick();
    end
    chk("rr_outstanding_1", 32'(src_outstanding), pk(1, 1, 1, 1));
    drive(4'b1111, 1'b1, 1'b0);
    tick();
    drive(4'b0000, 1'b1, 1'b0);
    chk("rr_outstanding_2", 32'(src_outstanding), pk(1, 1, 1, 2));
    chk("rr_head", 32'(head_src_id), 32'd0);
    for (int i = 0; i < 5; i++) begin
      drive(4'b0000, 1'b1, 1'b1);
      tick();
    end
    drive(4'b0000, 1'b1, 1'b0);
    chk("rr_drained", 32'(src_outstanding), pk(0, 0, 0, 0));
    chk("rr_drained_head_valid", 32'(head_src_valid), 32'd0);

    // Quota block on source 2
    for (int i = 0; i < 4; i++) begin
      exp_grant.push_back(2);
      drive(4'b0100, 1'b1, 1'b0);
      tick();
    end
    drive(4'b0100, 1'b1, 1'b0);
    chk("quota_wr_valid", 32'(fifo_wr_valid), 32'd0);
    chk("quota_src_ready", 32'(src_ready), 32'd0);
    chk("quota_outstanding", 32'(src_outstanding), pk(0, 4, 0, 0));
    tick();
    drive(4'b0100, 1'b1, 1'b1);
    chk("quota_pop_cycle_wr_valid", 32'(fifo_wr_valid), 32'd0);
    tick();
    exp_grant.push_back(2);
    drive(4'b0100, 1'b1, 1'b0);
    chk("quota_reaccept_ready", 32'(src_ready), 32'b0100);
    tick();
    drive(4'b0000, 1'b1, 1'b0);
    chk("quota_after_reaccept", 32'(src_outstanding), pk(0, 4, 0, 0));
    for (int i = 0; i < 4; i++) begin
      drive(4'b0000, 1'b1, 1'b1);
      tick();
    end
    drive(4'b0000, 1'b1, 1'b0);
    chk("quota_drained", 32'(src_outstanding), pk(0, 0, 0, 0));

    // Lock hold: source 1 stalled, source 0 raised meanwhile
    drive(4'b0010, 1'b0, 1'b0);
    chk("lock_wr_valid", 32'(fifo_wr_valid), 32'd1);
    chk("lock_data_0", fifo_wr_data, data_of(1));
    chk("lock_ready_low", 32'(src_ready), 32'd0);
    tick();
    drive(4'b0011, 1'b0, 1'b0);
    chk("lock_data_1", fifo_wr_data, data_of(1));
    tick();
    drive(4'b0011, 1'b0, 1'b0);
    chk("lock_data_2", fifo_wr_data, data_of(1));
    tick();
    exp_grant.push_back(1);
    exp_grant.push_back(0);
    drive(4'b0011, 1'b1, 1'b0);
    chk("lock_release_ready", 32'(src_ready), 32'b0010);
    tick();
    drive(4'b0011, 1'b1, 1'b0);
    chk("lock_next_ready", 32'(src_ready), 32'b0001);
    tick();
    drive(4'b0000, 1'b1, 1'b0);
    chk("lock_outstanding", 32'(src_outstanding), pk(0, 0, 1, 1));
    for (int i = 0; i < 2; i++) begin
      drive(4'b0000, 1'b1, 1'b1);
      tick();
    end

    // Simultaneous push and pop with head = source 3
    exp_grant.push_back(3); exp_grant.push_back(1); exp_grant.push_back(3);
    drive(4'b1000, 1'b1, 1'b0);
    tick();
    drive(4'b0010, 1'b1, 1'b0);
    tick();
    drive(4'b1000, 1'b1, 1'b1);
    chk("sim_head_before", 32'(head_src_id), 32'd3);
    tick();
    drive(4'b0000, 1'b1, 1'b0);
    chk("sim_outstanding", 32'(src_outstanding), pk(1, 0, 1, 0));
    chk("sim_head_after", 32'(head_src_id), 32'd1);
    for (int i = 0; i < 2; i++) begin
      drive(4'b0000, 1'b1, 1'b1);
      tick();
    end
    drive(4'b0000, 1'b1, 1'b0);
    chk("sim_count_empty", 32'(head_src_valid), 32'd0);
    chk("sim_drained", 32'(src_outstanding), pk(0, 0, 0, 0));

    // Tag wrap: 20 accepts, steady pops once three entries are queued
    for (int k = 0; k < 20; k++) begin
      exp_grant.push_back(k % 4);
      drive(4'(1 << (k % 4)), 1'b1, (k >= 3));
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(4'b0000, 1'b1, 1'b1);
      tick();
    end
    drive(4'b0000, 1'b1, 1'b0);
    chk("wrap_outstanding", 32'(src_outstanding), pk(0, 0, 0, 0));
    chk("wrap_head_valid", 32'(head_src_valid), 32'd0);

    // Underflow, sticky, then asynchronous clear
    chk("uf_before", 32'(err_underflow), 32'd0);
    drive(4'b0000, 1'b1, 1'b1);
    tick();
    drive(4'b0000, 1'b1, 1'b0);
    chk("uf_set", 32'(err_underflow), 32'd1);
    chk("uf_counts", 32'(src_outstanding), pk(0, 0, 0, 0));
    tick();
    chk("uf_sticky", 32'(err_underflow), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("uf_async_clear", 32'(err_underflow), 32'd0);

    chk("pending_grants", 32'(exp_grant.size()), 32'd0);
    chk("pending_tags", 32'(tag_model.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
